// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for a 5-stage RV32 pipeline: tracks the EX/MEM/WB writers,
// registers the EX operand-mux selects and raises load-use and memory-wait stalls/bubbles.
module hazard_forward_unit #(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   id_valid_i,
  input  logic [REG_AW-1:0]      id_rs1_i,
  input  logic [REG_AW-1:0]      id_rs2_i,
  input  logic                   id_uses_rs1_i,
  input  logic                   id_uses_rs2_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_reg_write_i,
  input  logic                   id_mem_read_i,
  input  logic                   flush_i,
  input  logic                   mem_busy_i,
  output logic [1:0]             fwd_sel_a_o,
  output logic [1:0]             fwd_sel_b_o,
  output logic                   stall_o,
  output logic                   bubble_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_e;

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] rd;
  } wr_t;

  typedef struct packed {
    logic mem_read;
    wr_t  wr;
  } ex_t;

  ex_t                    ex_q, ex_d;
  wr_t                    mem_q, wb_q;
  state_e                 state_q, state_d;
  logic [1:0][1:0]        sel_q, sel_d, sel_raw;
  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             src_use, ex_hit, mem_hit, wb_hit;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic                   load_use, kill_ex, lu_stall;

  assign src[0]     = id_rs1_i;
  assign src[1]     = id_rs2_i;
  assign src_use[0] = id_uses_rs1_i;
  assign src_use[1] = id_uses_rs2_i;

  // Operand 0 feeds mux A, operand 1 feeds mux B; x0 never matches.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic live;
      assign live        = id_valid_i & src_use[gi] & (src[gi] != '0);
      assign ex_hit[gi]  = live & ex_q.wr.reg_write & (ex_q.wr.rd == src[gi]);
      assign mem_hit[gi] = live & mem_q.reg_write & (mem_q.rd == src[gi]);
      assign wb_hit[gi]  = live & wb_q.reg_write & (wb_q.rd == src[gi]);
      assign sel_raw[gi] = ex_hit[gi]  ? 2'b01 :
                           mem_hit[gi] ? 2'b10 :
                           wb_hit[gi]  ? 2'b11 : 2'b00;
    end
  endgenerate

  // EX is always a bubble in LOAD_STALL, so the guard also prevents a repeat stall.
  assign load_use = (state_q != LOAD_STALL) & ex_q.mem_read & (|ex_hit);
  assign kill_ex  = flush_i | load_use;
  assign lu_stall = load_use & ~flush_i & ~mem_busy_i;

  always_comb begin
    ex_d  = '0;
    sel_d = '0;
    if (!kill_ex) begin
      ex_d.mem_read     = id_valid_i & id_mem_read_i;
      ex_d.wr.reg_write = id_valid_i & id_reg_write_i;
      ex_d.wr.rd        = id_rd_i;
      sel_d             = sel_raw;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (lu_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_busy_i) begin
          state_d = MEM_WAIT;
        end else if (lu_stall) begin
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = mem_busy_i ? MEM_WAIT : RUN;
      MEM_WAIT: begin
        if (!mem_busy_i) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      sel_q         <= '0;
      stall_count_q <= '0;
      state_q       <= RUN;
    end else begin
      state_q <= state_d;
      if (!mem_busy_i) begin
        ex_q          <= ex_d;
        mem_q         <= ex_q.wr;
        wb_q          <= mem_q;
        sel_q         <= sel_d;
        stall_count_q <= stall_count_d;
      end
    end
  end

  // Gated by reset so the combinational controls also drop the instant reset asserts.
  assign fwd_sel_a_o   = sel_q[0];
  assign fwd_sel_b_o   = sel_q[1];
  assign stall_o       = rst_ni & (mem_busy_i | lu_stall);
  assign bubble_o      = rst_ni & ~mem_busy_i & kill_ex;
  assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops one per cycle and compares. A 4-bit-counter instance covers saturation.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_u1 = 1'b0, id_u2 = 1'b0, id_rw = 1'b0, id_mr = 1'b0;
  logic       flush = 1'b0, busy = 1'b0;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        st, bu, st4, bu4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  hazard_forward_unit #(.REG_AW(5), .STALL_CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2),
    .id_rd_i(id_rd), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
    .flush_i(flush), .mem_busy_i(busy),
    .fwd_sel_a_o(fa), .fwd_sel_b_o(fb), .stall_o(st), .bubble_o(bu), .stall_count_o(cnt)
  );

  hazard_forward_unit #(.REG_AW(5), .STALL_CNT_W(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(id_u1), .id_uses_rs2_i(id_u2),
    .id_rd_i(id_rd), .id_reg_write_i(id_rw), .id_mem_read_i(id_mr),
    .flush_i(flush), .mem_busy_i(busy),
    .fwd_sel_a_o(fa4), .fwd_sel_b_o(fb4), .stall_o(st4), .bubble_o(bu4), .stall_count_o(cnt4)
  );

  // -1 in any field means "not checked this cycle".
  typedef struct {
    int tag;
    int a;
    int b;
    int st;
    int bu;
    int cnt;
    int sm;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   vec     = 0;

  task automatic check(input int tag, input string nm, input int exp_v, input int act_v);
    if (exp_v < 0) return;
    n_total++;
    if (act_v == exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL vec %0d %s: got %0d, expected %0d", tag, nm, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      $display("vec %0d: sel_a=%0d sel_b=%0d stall=%0b bubble=%0b count=%0d count4=%0d",
               e.tag, fa, fb, st, bu, cnt, cnt4);
      check(e.tag, "sel_a",   e.a,   int'(fa));
      check(e.tag, "sel_b",   e.b,   int'(fb));
      check(e.tag, "stall",   e.st,  int'(st));
      check(e.tag, "bubble",  e.bu,  int'(bu));
      check(e.tag, "count",   e.cnt, int'(cnt));
      check(e.tag, "sel_a4",  e.a,   int'(fa4));
      check(e.tag, "sel_b4",  e.b,   int'(fb4));
      check(e.tag, "stall4",  e.st,  int'(st4));
      check(e.tag, "bubble4", e.bu,  int'(bu4));
      check(e.tag, "count4",  e.sm,  int'(cnt4));
    end
  end

  // One pipeline cycle: drive the ID/control inputs and queue this cycle's expected outputs.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic fl, input logic bz,
                     input int a, input int b, input int s, input int bb,
                     input int c, input int sm);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_u1 = u1; id_u2 = u2;
    id_rd = rd; id_rw = rw; id_mr = mr; flush = fl; busy = bz;
    e.tag = vec; e.a = a; e.b = b; e.st = s; e.bu = bb; e.cnt = c; e.sm = sm;
    sb.push_back(e);
    vec++;
  endtask

  initial begin
    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    #5 rst_n = 1'b1;

    // Distance-1 forwarding on both operands
    cyc(1, 0, 0, 1, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, -1);   // addi x5
    cyc(1, 5, 5, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, -1);   // add x6,x5,x5
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, -1);

    // Distance 2, distance 3 (rs2 unused), x0 writer
    cyc(1, 0, 0, 1, 0, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0, -1);   // addi x9
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, -1);
    cyc(1, 9, 0, 1, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);   // add x10,x9,x0
    cyc(1, 0, 0, 1, 0, 9, 1, 0, 0, 0,  2, 0, 0, 0, 0, -1);   // addi x9
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, -1);
    cyc(1, 9, 9, 1, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);   // add x11,x9 (rs2 unused)
    cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0, -1);   // addi x0
    cyc(1, 0, 0, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1);   // add x12,x0,x0
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, -1);

    // Load-use: lw x7,0(x1); sub x8,x1,x7
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  0, 0, 1, 1, 0, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 1, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 1, -1);

    // Load-use under 3 cycles of MEM_BUSY: lw x7,0(x8) forwards x8 from MEM
    cyc(1, 8, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 1, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 1,  2, 0, 1, 0, 1, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 1,  2, 0, 1, 0, 1, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 1,  2, 0, 1, 0, 1, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  2, 0, 1, 1, 1, -1);
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  0, 0, 0, 0, 2, -1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 2, -1);

    // FLUSH coincident with load-use, then a consumer of the flushed x8 writer
    cyc(1, 0, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 2, -1);   // lw x7,0(x0)
    cyc(1, 1, 7, 1, 1, 8, 1, 0, 1, 0,  0, 0, 0, 1, 2, -1);   // sub x8,x1,x7 + FLUSH
    cyc(1, 8, 0, 1, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 2, -1);   // add x13,x8
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, -1);

    // Reset mid-stream with a load to x7 in EX
    cyc(1, 0, 0, 1, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 2, -1);   // addi x7
    cyc(1, 7, 0, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 2, -1);   // lw x7,0(x7)
    cyc(1, 7, 0, 1, 0, 8, 1, 0, 0, 1,  1, 0, 1, 0, 2, -1);   // add x8,x7 with MEM_BUSY
    cyc(1, 7, 0, 1, 0, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    cyc(1, 7, 0, 1, 0, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Repeated load-use stalls: 4-bit counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 1, 0, 7, 1, 1, 0, 0, -1, -1, 0, 0, k, (k < 15) ? k : 15);
      cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  0,  0, 1, 1, k, (k < 15) ? k : 15);
      cyc(1, 1, 7, 1, 1, 8, 1, 0, 0, 0,  0,  0, 0, 0, k + 1, (k + 1 < 15) ? k + 1 : 15);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 20, 15);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
